// File: rtl/disk_bridge.sv
// CPU data-bus slave for NUM_CH sector-buffered disk units: pass-through buffer access,
// blocking command FSM and status register. Optional WAIT timeout: DISK_BRIDGE_TIMEOUT_EN.
module disk_bridge #(
    parameter int BUF_AW      = 9,
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 STB,
    input  logic                 WE,
    input  logic [31:0]          ADDR,
    input  logic [31:0]          DAT_I,
    output logic [31:0]          DAT_O,
    output logic                 ACK,
    output logic [BUF_AW-1:0]    buf_addr,
    output logic [31:0]          buf_wdata,
    output logic [NUM_CH-1:0]    buf_we,
    input  logic [NUM_CH*32-1:0] buf_rdata,
    output logic [27:0]          cmd_lba,
    output logic [NUM_CH-1:0]    wr_start,
    output logic [NUM_CH-1:0]    rd_start,
    input  logic [NUM_CH-1:0]    op_done
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {RG_BUF, RG_CMD, RG_STAT, RG_UNMAP} region_t;

    state_t          state, state_nx;
    region_t         region;
    logic [CH_W-1:0] buf_idx;
    logic [CH_W-1:0] cmd_ch;
    logic [31:0]     cmd_q;
    logic [31:0]     status;
    logic            err_q;
    logic            to_bit;
    logic            tmo_hit;
    logic            new_ch_ok;
    logic            cmd_wr;
    logic            accept;
    logic            bad_cmd;
    logic            stat_wr;
    logic            unused_addr;

    assign region      = region_t'(ADDR[BUF_AW+1:BUF_AW]);
    assign buf_idx     = ADDR[BUF_AW+2 +: CH_W];
    assign unused_addr = ^ADDR[31:BUF_AW+2+CH_W];
    assign buf_addr    = ADDR[BUF_AW-1:0];
    assign buf_wdata   = DAT_I;
    assign cmd_lba     = cmd_q[27:0];
    assign cmd_ch      = cmd_q[28 +: CH_W];

    assign new_ch_ok = int'(DAT_I[30:28]) < NUM_CH;
    assign cmd_wr    = STB && WE && (region == RG_CMD);
    assign accept    = (state == S_IDLE) && cmd_wr && new_ch_ok;
    assign bad_cmd   = (state == S_IDLE) && cmd_wr && !new_ch_ok;
    assign stat_wr   = STB && WE && (region == RG_STAT);

    assign status = {state != S_IDLE, err_q, to_bit, cmd_q[31], 25'b0, cmd_q[30:28]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A fault (bad channel or timeout) outranks a same-cycle status clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= DAT_I;
            end
            if (accept || stat_wr) begin
                err_q <= 1'b0;
            end
            if (bad_cmd || tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef DISK_BRIDGE_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        wait_armed;
    logic        to_q;

    // The first WAIT cycle only clears the counter; counting starts the cycle after.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) begin
            wait_cnt   <= '0;
            wait_armed <= 1'b0;
        end else if (!wait_armed) begin
            wait_cnt   <= '0;
            wait_armed <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign tmo_hit = (state == S_WAIT) && wait_armed && !op_done[cmd_ch]
                     && (wait_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= 1'b0;
        end else begin
            if (accept || stat_wr) begin
                to_q <= 1'b0;
            end
            if (tmo_hit) begin
                to_q <= 1'b1;
            end
        end
    end

    assign to_bit = to_q;
`else
    assign tmo_hit = 1'b0;
    assign to_bit  = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        wr_start = '0;
        rd_start = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!rst) begin
                    if (cmd_q[31]) begin
                        wr_start[cmd_ch] = 1'b1;
                    end else begin
                        rd_start[cmd_ch] = 1'b1;
                    end
                end
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (op_done[cmd_ch] || tmo_hit) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        DAT_O  = '0;
        ACK    = 1'b0;
        buf_we = '0;
        case (region)
            RG_BUF: begin
                ACK = STB;
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (32'(buf_idx) == k) begin
                        DAT_O     = buf_rdata[32*k +: 32];
                        buf_we[k] = STB && WE;
                    end
                end
            end
            RG_CMD: begin
                DAT_O = cmd_q;
                if (!WE) begin
                    ACK = STB;
                end else if (state == S_IDLE) begin
                    ACK = STB && !new_ch_ok;
                end else if (state == S_DONE) begin
                    ACK = STB && !rst;
                end
            end
            RG_STAT: begin
                DAT_O = status;
                ACK   = STB;
            end
            default: ACK = STB;
        endcase
    end

endmodule

// File: tb/tb_disk_bridge.sv
// Self-checking bench for disk_bridge (NUM_CH=2, BUF_AW=9, TIMEOUT_CYC=8); timeout
// scenarios are exercised when DISK_BRIDGE_TIMEOUT_EN is defined.
module tb_disk_bridge;

    localparam logic [31:0] A_CMD  = 32'h0000_0200;
    localparam logic [31:0] A_STAT = 32'h0000_0400;
    localparam logic [31:0] A_UNM  = 32'h0000_0600;

    logic        clk = 1'b0;
    logic        rst;
    logic        STB, WE;
    logic [31:0] ADDR, DAT_I, DAT_O;
    logic        ACK;
    logic [8:0]  buf_addr;
    logic [31:0] buf_wdata;
    logic [1:0]  buf_we;
    logic [63:0] buf_rdata;
    logic [27:0] cmd_lba;
    logic [1:0]  wr_start, rd_start, op_done;

    int          asserts = 0;
    int          fails   = 0;
    logic [31:0] last_cmd = '0;

    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];
    logic [31:0] shadow [2][512];

    disk_bridge #(.BUF_AW(9), .NUM_CH(2), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
        .DAT_O(DAT_O), .ACK(ACK), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .buf_we(buf_we), .buf_rdata(buf_rdata), .cmd_lba(cmd_lba),
        .wr_start(wr_start), .rd_start(rd_start), .op_done(op_done)
    );

    always #5 clk = ~clk;

    assign buf_rdata = {mem1[buf_addr], mem0[buf_addr]};

    always @(posedge clk) begin
        if (buf_we[0]) mem0[buf_addr] <= buf_wdata;
        if (buf_we[1]) mem1[buf_addr] <= buf_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0; op_done = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_idle();
        tick(); tick();
        rst = 1'b0;
        STB = 1'b1; WE = 1'b0; ADDR = A_STAT;
        #1;
        asserts++; if (DAT_O !== 32'h0) begin fails++; $display("FAIL reset_status: got %h exp 00000000", DAT_O); end
        asserts++; if (ACK !== 1'b1) begin fails++; $display("FAIL reset_status_ack: got %b exp 1", ACK); end
        asserts++; if ({wr_start, rd_start, buf_we} !== 6'b0) begin fails++; $display("FAIL reset_strobes: got %b exp 0", {wr_start, rd_start, buf_we}); end
        asserts++; if (cmd_lba !== 28'h0) begin fails++; $display("FAIL reset_lba: got %h exp 0", cmd_lba); end
        ADDR = A_CMD;
        #1;
        asserts++; if (DAT_O !== 32'h0 || ACK !== 1'b1) begin fails++; $display("FAIL reset_cmd_read: got %h/%b exp 00000000/1", DAT_O, ACK); end
        STB = 1'b0;
        #1;
        asserts++; if (ACK !== 1'b0) begin fails++; $display("FAIL reset_no_stb_ack: got %b exp 0", ACK); end
        tick();
    endtask

    task automatic test_buffer;
        logic [31:0] hi, data, exp_d;
        logic [1:0]  exp_we;
        int          ch, word;
        bit          stb, we;
        STB = 1'b1; WE = 1'b1; ADDR = (32'd1 << 11) | 32'd5; DAT_I = 32'h1234;
        #1;
        asserts++; if (buf_we !== 2'b10 || ACK !== 1'b1) begin fails++; $display("FAIL buf_wr_dir: we=%b ack=%b exp 10/1", buf_we, ACK); end
        asserts++; if (buf_addr !== 9'd5 || buf_wdata !== 32'h1234) begin fails++; $display("FAIL buf_wr_pass: addr=%h data=%h exp 005/00001234", buf_addr, buf_wdata); end
        shadow[1][5] = 32'h1234;
        tick();
        WE = 1'b0; DAT_I = '0;
        #1;
        asserts++; if (DAT_O !== 32'h1234 || ACK !== 1'b1 || buf_we !== 2'b00) begin fails++; $display("FAIL buf_rd_dir: dat=%h ack=%b we=%b exp 00001234/1/00", DAT_O, ACK, buf_we); end
        tick();
        for (int i = 0; i < 40; i++) begin
            ch = $urandom_range(0, 1); word = $urandom_range(0, 7);
            stb = ($urandom % 4) != 0; we = $urandom % 2;
            hi = $urandom; data = $urandom;
            STB = stb; WE = we; DAT_I = data;
            ADDR = {hi[31:12], 1'(ch), 2'b00, 9'(word)};
            exp_we = (stb && we) ? (2'b01 << ch) : 2'b00;
            exp_d  = shadow[ch][word];
            #1;
            asserts++; if (DAT_O !== exp_d) begin fails++; $display("FAIL buf_rand_dat: ch%0d w%0d got %h exp %h", ch, word, DAT_O, exp_d); end
            asserts++; if (buf_we !== exp_we) begin fails++; $display("FAIL buf_rand_we: got %b exp %b", buf_we, exp_we); end
            asserts++; if (ACK !== stb) begin fails++; $display("FAIL buf_rand_ack: got %b exp %b", ACK, stb); end
            if (stb && we) shadow[ch][word] = data;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            hi = $urandom;
            STB = 1'b1; WE = hi[0]; ADDR = A_UNM | {23'b0, hi[8:0]}; DAT_I = $urandom;
            #1;
            asserts++; if (DAT_O !== 32'h0 || ACK !== 1'b1 || buf_we !== 2'b00) begin fails++; $display("FAIL unmapped: dat=%h ack=%b we=%b exp 0/1/00", DAT_O, ACK, buf_we); end
            tick();
        end
        bus_idle();
    endtask

    // other_mode: 0 = other channel's op_done low, 1 = held high, 2 = random noise
    task automatic run_cmd(input logic [31:0] cmd, input int done_at, input int other_mode);
        int          ch;
        bit          dir, exp_ack;
        logic [1:0]  exp_wr, exp_rd;
        logic [31:0] exp_stat;
        ch  = int'(cmd[30:28]);
        dir = cmd[31];
        for (int c = 0; c <= done_at + 1; c++) begin
            STB = 1'b1; WE = 1'b1; ADDR = A_CMD; DAT_I = cmd;
            op_done = '0;
            if (other_mode == 1) op_done[1-ch] = 1'b1;
            if (other_mode == 2) op_done[1-ch] = 1'($urandom);
            if (other_mode == 2 && c < 2) op_done[ch] = 1'($urandom);
            if (c == done_at) op_done[ch] = 1'b1;
            exp_ack = (c == done_at + 1);
            exp_wr  = (c == 1 && dir)  ? (2'b01 << ch) : 2'b00;
            exp_rd  = (c == 1 && !dir) ? (2'b01 << ch) : 2'b00;
            #1;
            asserts++; if (ACK !== exp_ack) begin fails++; $display("FAIL cmd_ack %h c=%0d: got %b exp %b", cmd, c, ACK, exp_ack); end
            asserts++; if (wr_start !== exp_wr || rd_start !== exp_rd) begin fails++; $display("FAIL cmd_start %h c=%0d: wr=%b rd=%b exp %b/%b", cmd, c, wr_start, rd_start, exp_wr, exp_rd); end
            if (c == 1) begin
                asserts++; if (cmd_lba !== cmd[27:0]) begin fails++; $display("FAIL cmd_lba: got %h exp %h", cmd_lba, cmd[27:0]); end
            end
            tick();
        end
        last_cmd = cmd;
        op_done = '0;
        STB = 1'b1; WE = 1'b0; ADDR = A_STAT;
        exp_stat = {3'b000, dir, 25'b0, cmd[30:28]};
        #1;
        asserts++; if (DAT_O !== exp_stat) begin fails++; $display("FAIL cmd_status: got %h exp %h", DAT_O, exp_stat); end
        ADDR = A_CMD;
        #1;
        asserts++; if (DAT_O !== cmd || ACK !== 1'b1) begin fails++; $display("FAIL cmd_readback: got %h/%b exp %h/1", DAT_O, ACK, cmd); end
        tick();
        bus_idle();
    endtask

    task automatic test_command;
        logic [31:0] r;
        run_cmd(32'h8000_0042, 5, 0);
        run_cmd(32'h1000_0007, 4, 1);
        run_cmd(32'h0000_0003, 2, 2);
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            run_cmd({r[31], 2'b00, r[28], r[27:0]}, $urandom_range(2, 7), 2);
        end
    endtask

    task automatic test_busy_poll;
        STB = 1'b1; WE = 1'b1; ADDR = A_CMD; DAT_I = 32'h8000_0042;
        tick();
        for (int c = 1; c <= 5; c++) begin
            STB = 1'b1; WE = 1'b0; ADDR = A_STAT; op_done = (c == 5) ? 2'b01 : 2'b00;
            #1;
            asserts++; if (DAT_O !== 32'h9000_0000 || ACK !== 1'b1) begin fails++; $display("FAIL busy_poll c=%0d: got %h/%b exp 90000000/1", c, DAT_O, ACK); end
            asserts++; if (wr_start !== ((c == 1) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL busy_start c=%0d: got %b", c, wr_start); end
            tick();
        end
        bus_idle();
        ADDR = A_CMD; WE = 1'b1;
        #1;
        asserts++; if (ACK !== 1'b0) begin fails++; $display("FAIL dropped_stb_ack: got %b exp 0", ACK); end
        tick();
        STB = 1'b1; WE = 1'b0; ADDR = A_STAT;
        #1;
        asserts++; if (DAT_O !== 32'h1000_0000) begin fails++; $display("FAIL busy_clear: got %h exp 10000000", DAT_O); end
        last_cmd = 32'h8000_0042;
        tick();
        bus_idle();
    endtask

    task automatic test_bad_channel;
        logic [31:0] r;
        for (int ch = 2; ch < 8; ch++) begin
            r = $urandom;
            STB = 1'b1; WE = 1'b1; ADDR = A_CMD; DAT_I = {r[31], 3'(ch), r[27:0]};
            #1;
            asserts++; if (ACK !== 1'b1 || wr_start !== 2'b00 || rd_start !== 2'b00) begin fails++; $display("FAIL bad_ch%0d: ack=%b wr=%b rd=%b exp 1/00/00", ch, ACK, wr_start, rd_start); end
            tick();
            bus_idle();
            #1;
            asserts++; if (wr_start !== 2'b00 || rd_start !== 2'b00) begin fails++; $display("FAIL bad_ch_nopulse: wr=%b rd=%b", wr_start, rd_start); end
            tick();
        end
        STB = 1'b1; WE = 1'b0; ADDR = A_STAT;
        #1;
        asserts++; if (DAT_O[31:29] !== 3'b010) begin fails++; $display("FAIL bad_ch_err: got %b exp 010", DAT_O[31:29]); end
        ADDR = A_CMD;
        #1;
        asserts++; if (DAT_O !== last_cmd) begin fails++; $display("FAIL bad_ch_nolatch: got %h exp %h", DAT_O, last_cmd); end
        tick();
        WE = 1'b1; ADDR = A_STAT; DAT_I = $urandom;
        #1;
        asserts++; if (ACK !== 1'b1) begin fails++; $display("FAIL stat_wr_ack: got %b exp 1", ACK); end
        tick();
        WE = 1'b0;
        #1;
        asserts++; if (DAT_O[30:29] !== 2'b00) begin fails++; $display("FAIL stat_clear: got %b exp 00", DAT_O[30:29]); end
        tick();
        WE = 1'b1; ADDR = A_CMD; DAT_I = 32'h5000_0000;
        tick();
        bus_idle();
        run_cmd(32'h0000_0abc, 3, 0);
    endtask

    task automatic test_reset_mid;
        STB = 1'b1; WE = 1'b1; ADDR = A_CMD; DAT_I = 32'h8000_0011;
        tick();
        rst = 1'b1;
        #1;
        asserts++; if (wr_start !== 2'b00 || ACK !== 1'b0) begin fails++; $display("FAIL rst_issue: wr=%b ack=%b exp 00/0", wr_start, ACK); end
        tick();
        rst = 1'b0; WE = 1'b0; ADDR = A_STAT;
        #1;
        asserts++; if (DAT_O !== 32'h0) begin fails++; $display("FAIL rst_issue_status: got %h exp 0", DAT_O); end
        tick();
        WE = 1'b1; ADDR = A_CMD; DAT_I = 32'h0000_0022;
        tick();
        #1;
        asserts++; if (rd_start !== 2'b01) begin fails++; $display("FAIL rst_pre_pulse: got %b exp 01", rd_start); end
        tick();
        op_done = 2'b01;
        tick();
        op_done = 2'b00; rst = 1'b1;
        #1;
        asserts++; if (ACK !== 1'b0) begin fails++; $display("FAIL rst_done_ack: got %b exp 0", ACK); end
        tick();
        rst = 1'b0; WE = 1'b0; ADDR = A_STAT;
        #1;
        asserts++; if (DAT_O !== 32'h0) begin fails++; $display("FAIL rst_done_status: got %h exp 0", DAT_O); end
        last_cmd = '0;
        tick();
        bus_idle();
    endtask

`ifdef DISK_BRIDGE_TIMEOUT_EN
    task automatic test_timeout;
        for (int c = 0; c <= 11; c++) begin
            STB = 1'b1; WE = 1'b1; ADDR = A_CMD; DAT_I = 32'h8000_0099;
            #1;
            asserts++; if (ACK !== (c == 11)) begin fails++; $display("FAIL tmo_ack c=%0d: got %b exp %b", c, ACK, (c == 11)); end
            tick();
        end
        last_cmd = 32'h8000_0099;
        WE = 1'b0; ADDR = A_STAT;
        #1;
        asserts++; if (DAT_O[31:29] !== 3'b011) begin fails++; $display("FAIL tmo_status: got %b exp 011", DAT_O[31:29]); end
        tick();
        bus_idle();
        run_cmd(32'h1000_0055, 10, 0);
        for (int c = 0; c <= 4; c++) begin
            STB = 1'b1; WE = 1'b1; ADDR = A_CMD; DAT_I = 32'h8000_0077;
            rst = (c == 4);
            #1;
            asserts++; if (ACK !== 1'b0) begin fails++; $display("FAIL tmo_rst_ack c=%0d: got %b exp 0", c, ACK); end
            tick();
        end
        rst = 1'b0; WE = 1'b0; ADDR = A_STAT;
        #1;
        asserts++; if (DAT_O !== 32'h0) begin fails++; $display("FAIL tmo_rst_idle: got %h exp 0", DAT_O); end
        last_cmd = '0;
        tick();
        bus_idle();
    endtask
`else
    task automatic test_timeout;
        run_cmd(32'h8000_0123, 30, 2);
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem0[i] = '0; mem1[i] = '0; shadow[0][i] = '0; shadow[1][i] = '0;
        end
        rst = 1'b1;
        bus_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_buffer();
        test_command();
        test_busy_poll();
        test_bad_channel();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/disk_bridge.md
# disk_bridge

Bus-slave bridge between the CPU data bus and a bank of NUM_CH sector-buffered disk units. Buffer accesses pass straight through and acknowledge in the same cycle. Writes to the command register launch a blocking sector read or write on one channel through a four-state FSM that issues a one-cycle start pulse and acknowledges the bus only on completion. A readable and clearable status register reports busy, error and timeout.

## Interface
- BUF_AW, 9, word-address width of each channel's sector buffer
- NUM_CH, 2, number of disk channels (2..8); CH_W = clog2(NUM_CH)
- TIMEOUT_CYC, 1000000, WAIT-state cycle limit (used only with the timeout macro)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- STB  in  1  bus strobe
- WE  in  1  bus write enable
- ADDR  in  32  bus word address
- DAT_I  in  32  bus write data
- DAT_O  out  32  bus read data
- ACK  out  1  bus acknowledge (combinational)
- buf_addr  out  BUF_AW  buffer word address, = ADDR[BUF_AW-1:0]
- buf_wdata  out  32  buffer write data, = DAT_I
- buf_we  out  NUM_CH  one-hot buffer write strobe
- buf_rdata  in  NUM_CH*32  flattened buffer read data; channel k at [32k+31:32k]
- cmd_lba  out  28  latched sector number
- wr_start  out  NUM_CH  one-cycle pulse: write buffer to disk
- rd_start  out  NUM_CH  one-cycle pulse: read disk into buffer
- op_done  in  NUM_CH  per-channel completion level or pulse

## Operation
- Region is selected by ADDR[BUF_AW+1:BUF_AW]: 00 buffer, 01 command, 10 status, 11 unmapped.
- Buffer region:
  - Channel index is ADDR[BUF_AW+2+CH_W-1:BUF_AW+2].
  - DAT_O returns that channel's buf_rdata slice.
  - buf_we[idx] = STB & WE.
  - ACK = STB.
  - If idx >= NUM_CH: DAT_O = 0, no buf_we, ACK = STB.
  - Buffer access is allowed in any FSM state.
- Command word: [31] dir (1 = write, 0 = read), [30:28] channel, [27:0] LBA.
- Command write (STB & WE in region 01):
  - Accepted only in IDLE. Outside IDLE there is no ACK; the request waits until the FSM returns to IDLE.
  - Valid channel: latch command, clear err/timeout, go to ISSUE.
  - Channel >= NUM_CH: set err, ACK = STB in the same cycle, no start pulse, stay in IDLE.
- Command read returns the latched command word; ACK = STB.
- Status register: [31] busy (state != IDLE), [30] err, [29] timeout, [28] last dir, [2:0] last channel, other bits 0.
  - Read: ACK = STB.
  - Write: clears err and timeout; ACK = STB.
- Unmapped region: DAT_O = 0, ACK = STB.
- FSM states:
  - IDLE → ISSUE on an accepted valid command.
  - ISSUE: assert wr_start[ch] or rd_start[ch] for exactly one cycle, then → WAIT.
  - WAIT: sample op_done[ch] only; when high → DONE. op_done from other channels and op_done outside WAIT are ignored.
  - DONE: ACK = STB & region 01 for one cycle, then → IDLE unconditionally.
- If the master drops STB mid-operation, the operation still completes and no ACK is issued.

## Timing
- Reset values:
  - FSM in IDLE; cmd_lba = 0; wr_start, rd_start, buf_we = 0.
  - Status register and latched command = 0.
  - DAT_O reflects the current address (combinational); ACK = STB for non-command regions.
- Command timing:
  - Accept at cycle 0, start pulse at cycle 1, WAIT from cycle 2.
  - op_done first seen at cycle n ≥ 2 gives ACK at cycle n+1.
  - Minimum command latency is 3 cycles.
- Buffer, status and unmapped accesses: zero-latency ACK.
- Reset during ISSUE, WAIT or DONE: next cycle is IDLE, the pending pulse is cancelled, and no ACK is given.
- Command write and op_done in the same cycle in IDLE: op_done is ignored and the command is accepted.

## Configuration
- DISK_BRIDGE_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When count = TIMEOUT_CYC-1 without op_done: go to DONE and set err and timeout.
  - op_done in that same cycle wins: no error.
- Undefined: WAIT lasts indefinitely; status[29] reads 0; the counter is not built.

## Test plan
- Reset, then read status (ADDR region 10) → DAT_O = 0x00000000, ACK in the same cycle.
- Write 0x1234 to channel 1 buffer word 5, then read it back → buf_we = 2'b10 on write; DAT_O = buf_rdata[63:32]; ACK = STB on both.
- Command 0x8000_0042 on NUM_CH = 2 → wr_start = 2'b01 for one cycle at cycle 1; cmd_lba = 0x42; op_done[0] raised at cycle 5 → ACK at cycle 6; status[31] = 1 during cycles 1–6.
- Command 0x1000_0007 (read, ch 1) with op_done[0] held high → no ACK; op_done[1] at cycle 4 → ACK at cycle 5.
- Command with channel 3 on NUM_CH = 2 → immediate ACK, no start pulse, status[30] = 1; status write clears it.
- With DISK_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC = 8, no op_done → ACK at cycle 11, status[30:29] = 2'b11; repeat with reset at cycle 4 → no ACK, FSM IDLE.
